// File: rtl/operand_fetch_stage.sv
// Operand fetch / ID-EX pipeline stage with load-use stall and flush.
// Optional OPFETCH_WB_BYPASS_EN: writeback bypass mux instead of a writeback stall.
`timescale 1ns/1ps
module operand_fetch_stage #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   NOP_INSN = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_insn_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic            id_regwren_i,
  input  logic            id_memread_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  input  logic [XLEN-1:0] rs1data_i,
  input  logic [XLEN-1:0] rs2data_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_datawb_i,
  input  logic            wb_regwren_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_insn_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_rs1data_o,
  output logic [XLEN-1:0] ex_rs2data_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_regwren_o,
  output logic            ex_memread_o
);

  logic            load_en;
  logic            luh;
  logic            wbh;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rs1_o = id_rs1_i;
  assign rs2_o = id_rs2_i;

  assign load_en = !ex_valid_o || ex_ready_i;

  // A load in EX cannot forward its data in time for a dependent reader.
  assign luh = ex_valid_o && ex_memread_o && ex_regwren_o && (ex_rd_o != 5'd0) &&
               ((id_uses_rs1_i && (id_rs1_i == ex_rd_o)) ||
                (id_uses_rs2_i && (id_rs2_i == ex_rd_o)));

`ifdef OPFETCH_WB_BYPASS_EN
  assign wbh = 1'b0;

  always_comb begin
    op1 = rs1data_i;
    op2 = rs2data_i;
    if (id_rs1_i == 5'd0)                                 op1 = '0;
    else if (wb_regwren_i && (wb_rd_i == id_rs1_i))       op1 = wb_datawb_i;
    if (id_rs2_i == 5'd0)                                 op2 = '0;
    else if (wb_regwren_i && (wb_rd_i == id_rs2_i))       op2 = wb_datawb_i;
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_datawb_i;

  // Without bypass, wait one cycle for the register file to hold the new value.
  assign wbh = wb_regwren_i && (wb_rd_i != 5'd0) &&
               ((id_uses_rs1_i && (id_rs1_i == wb_rd_i)) ||
                (id_uses_rs2_i && (id_rs2_i == wb_rd_i)));

  always_comb begin
    op1 = rs1data_i;
    op2 = rs2data_i;
    if (id_rs1_i == 5'd0) op1 = '0;
    if (id_rs2_i == 5'd0) op2 = '0;
  end
`endif

  assign hazard     = luh || wbh;
  assign capture    = load_en && id_valid_i && !hazard;
  assign id_ready_o = rst && (flush_i || (load_en && !hazard));

  // ID/EX pipeline register: flush, capture, bubble, hold in priority order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_insn_o    <= NOP_INSN;
      ex_imm_o     <= '0;
      ex_rs1data_o <= '0;
      ex_rs2data_o <= '0;
      ex_rd_o      <= 5'd0;
      ex_regwren_o <= 1'b0;
      ex_memread_o <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_insn_o  <= NOP_INSN;
    end else if (capture) begin
      ex_valid_o   <= 1'b1;
      ex_pc_o      <= id_pc_i;
      ex_insn_o    <= id_insn_i;
      ex_imm_o     <= id_imm_i;
      ex_rs1data_o <= op1;
      ex_rs2data_o <= op2;
      ex_rd_o      <= id_rd_i;
      ex_regwren_o <= id_regwren_i && (id_rd_i != 5'd0);
      ex_memread_o <= id_memread_i;
    end else if (load_en) begin
      ex_valid_o   <= 1'b0;
      ex_insn_o    <= NOP_INSN;
      ex_regwren_o <= 1'b0;
      ex_memread_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: vector table plus stall/flush/reset sequences.
`timescale 1ns/1ps
module tb_operand_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_ready_o;
  logic [31:0] id_pc_i, id_insn_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i, id_regwren_i, id_memread_i;
  logic [4:0]  rs1_o, rs2_o;
  logic [31:0] rs1data_i, rs2data_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_datawb_i;
  logic        wb_regwren_i, flush_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] ex_pc_o, ex_insn_o, ex_imm_o, ex_rs1data_o, ex_rs2data_o;
  logic [4:0]  ex_rd_o;
  logic        ex_regwren_o, ex_memread_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_insn_i(id_insn_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_regwren_i(id_regwren_i), .id_memread_i(id_memread_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs1data_i(rs1data_i), .rs2data_i(rs2data_i),
    .wb_rd_i(wb_rd_i), .wb_datawb_i(wb_datawb_i), .wb_regwren_i(wb_regwren_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_insn_o(ex_insn_o), .ex_imm_o(ex_imm_o),
    .ex_rs1data_o(ex_rs1data_o), .ex_rs2data_o(ex_rs2data_o),
    .ex_rd_o(ex_rd_o), .ex_regwren_o(ex_regwren_o), .ex_memread_o(ex_memread_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wren, mrd, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] insn, d1, d2, wb_data;
    logic [31:0] e1, e2;
    logic        e_wren, e_mrd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wren, input logic mrd,
                       input logic [31:0] insn, input logic [31:0] d1, input logic [31:0] d2);
    id_valid_i = 1'b1; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_uses_rs1_i = u1; id_uses_rs2_i = u2; id_regwren_i = wren; id_memread_i = mrd;
    id_insn_i = insn; rs1data_i = d1; rs2data_i = d2;
    id_pc_i = 32'h0000_2000; id_imm_i = 32'hFFFF_FFF0;
  endtask

  initial begin
    rst = 1'b0; id_valid_i = 1'b0; id_pc_i = '0; id_insn_i = '0; id_imm_i = '0;
    id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
    id_regwren_i = 1'b0; id_memread_i = 1'b0; rs1data_i = '0; rs2data_i = '0;
    wb_rd_i = '0; wb_datawb_i = '0; wb_regwren_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;

    //            rs1    rs2    rd     u1 u2 wr mr wb wbrd  insn           d1            d2            wbdata  e1            e2            ewr  emr
    tbl[0] = '{5'd1,  5'd2,  5'd3,  1, 1, 1, 0, 0, 5'd0, 32'h002081b3, 32'd5,        32'd7,        32'd0,   32'd5,        32'd7,        1'b1, 1'b0};
    tbl[1] = '{5'd4,  5'd6,  5'd8,  1, 1, 1, 0, 0, 5'd0, 32'h00620433, 32'hAAAA0001, 32'h0000FFFF, 32'd0,   32'hAAAA0001, 32'h0000FFFF, 1'b1, 1'b0};
    tbl[2] = '{5'd0,  5'd2,  5'd5,  1, 1, 1, 0, 1, 5'd0, 32'h002002b3, 32'h1234,     32'd99,       32'd555, 32'd0,        32'd99,       1'b1, 1'b0};
    tbl[3] = '{5'd10, 5'd11, 5'd0,  1, 1, 1, 0, 0, 5'd0, 32'h00b50033, 32'd1,        32'd2,        32'd0,   32'd1,        32'd2,        1'b0, 1'b0};
    tbl[4] = '{5'd1,  5'd2,  5'd4,  1, 1, 1, 0, 1, 5'd9, 32'h00208233, 32'd3,        32'd4,        32'd42,  32'd3,        32'd4,        1'b1, 1'b0};
    tbl[5] = '{5'd13, 5'd14, 5'd12, 1, 0, 1, 1, 0, 5'd0, 32'h0006a603, 32'd5,        32'd6,        32'd0,   32'd5,        32'd6,        1'b1, 1'b1};
    tbl[6] = '{5'd0,  5'd0,  5'd1,  1, 1, 0, 0, 0, 5'd0, 32'h00002023, 32'hFF,       32'hFF,       32'd0,   32'd0,        32'd0,        1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_insn", ex_insn_o, NOP);
    chk("rst_pc", ex_pc_o, 32'd0);
    chk("rst_imm", ex_imm_o, 32'd0);
    chk("rst_rs1data", ex_rs1data_o, 32'd0);
    chk("rst_rs2data", ex_rs2data_o, 32'd0);
    chk("rst_ctl", {27'd0, ex_rd_o}, 32'd0);
    chk("rst_wren_mrd", 32'({ex_regwren_o, ex_memread_o}), 32'd0);
    chk("rst_ready", 32'(id_ready_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(id_ready_o), 32'd1);
    tick();

    // Back-to-back streaming through the vector table
    for (int i = 0; i < 7; i++) begin
      id_valid_i = 1'b1;
      id_rs1_i = tbl[i].rs1; id_rs2_i = tbl[i].rs2; id_rd_i = tbl[i].rd;
      id_uses_rs1_i = tbl[i].u1; id_uses_rs2_i = tbl[i].u2;
      id_regwren_i = tbl[i].wren; id_memread_i = tbl[i].mrd;
      id_insn_i = tbl[i].insn; rs1data_i = tbl[i].d1; rs2data_i = tbl[i].d2;
      wb_regwren_i = tbl[i].wb_en; wb_rd_i = tbl[i].wb_rd; wb_datawb_i = tbl[i].wb_data;
      id_pc_i = 32'h100 + 32'(i) * 32'd4; id_imm_i = 32'(i) * 32'd3;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(id_ready_o), 32'd1);
      chk($sformatf("v%0d_raddr", i), {22'd0, rs1_o, rs2_o}, {22'd0, tbl[i].rs1, tbl[i].rs2});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(ex_valid_o), 32'd1);
      chk($sformatf("v%0d_insn", i), ex_insn_o, tbl[i].insn);
      chk($sformatf("v%0d_pc", i), ex_pc_o, 32'h100 + 32'(i) * 32'd4);
      chk($sformatf("v%0d_imm", i), ex_imm_o, 32'(i) * 32'd3);
      chk($sformatf("v%0d_rs1data", i), ex_rs1data_o, tbl[i].e1);
      chk($sformatf("v%0d_rs2data", i), ex_rs2data_o, tbl[i].e2);
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd_o}, {27'd0, tbl[i].rd});
      chk($sformatf("v%0d_wren", i), 32'(ex_regwren_o), 32'(tbl[i].e_wren));
      chk($sformatf("v%0d_memread", i), 32'(ex_memread_o), 32'(tbl[i].e_mrd));
    end
    wb_regwren_i = 1'b0; wb_rd_i = '0; wb_datawb_i = '0;

    // Bubble when decode offers nothing
    id_valid_i = 1'b0;
    tick();
    chk("bubble_valid", 32'(ex_valid_o), 32'd0);
    chk("bubble_insn", ex_insn_o, NOP);
    chk("bubble_ctl", 32'({ex_regwren_o, ex_memread_o}), 32'd0);

    // Writeback collision on x5
    offer(5'd5, 5'd0, 5'd9, 1, 1, 1, 0, 32'h000284b3, 32'd123, 32'd0);
    wb_regwren_i = 1'b1; wb_rd_i = 5'd5; wb_datawb_i = 32'd777;
    #1;
`ifdef OPFETCH_WB_BYPASS_EN
    chk("wbc_ready", 32'(id_ready_o), 32'd1);
    tick();
`else
    chk("wbc_stall", 32'(id_ready_o), 32'd0);
    tick();
    chk("wbc_stall_valid", 32'(ex_valid_o), 32'd0);
    wb_regwren_i = 1'b0; rs1data_i = 32'd777;
    #1;
    chk("wbc_ready", 32'(id_ready_o), 32'd1);
    tick();
`endif
    wb_regwren_i = 1'b0; wb_rd_i = '0; wb_datawb_i = '0;
    chk("wbc_valid", 32'(ex_valid_o), 32'd1);
    chk("wbc_rs1data", ex_rs1data_o, 32'd777);

    // Load-use: LW x6 then ADD x7,x6,x0
    offer(5'd1, 5'd0, 5'd6, 1, 0, 1, 1, 32'h0000a303, 32'd0, 32'd0);
    tick();
    offer(5'd6, 5'd0, 5'd7, 1, 1, 1, 0, 32'h000303b3, 32'h66, 32'd0);
    #1;
    chk("lu_stall", 32'(id_ready_o), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
    chk("lu_bubble_insn", ex_insn_o, NOP);
    chk("lu_ready", 32'(id_ready_o), 32'd1);
    tick();
    chk("lu_valid", 32'(ex_valid_o), 32'd1);
    chk("lu_rd", {27'd0, ex_rd_o}, 32'd7);
    chk("lu_rs1data", ex_rs1data_o, 32'h66);

    // Backpressure for 3 cycles, then flush while still backpressured
    ex_ready_i = 1'b0;
    offer(5'd1, 5'd2, 5'd9, 1, 1, 1, 0, 32'h002084b3, 32'd11, 32'd22);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), 32'(id_ready_o), 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(ex_valid_o), 32'd1);
      chk($sformatf("bp%0d_insn", c), ex_insn_o, 32'h000303b3);
      chk($sformatf("bp%0d_rs1data", c), ex_rs1data_o, 32'h66);
    end
    flush_i = 1'b1;
    #1;
    chk("fl_ready", 32'(id_ready_o), 32'd1);
    tick();
    chk("fl_valid", 32'(ex_valid_o), 32'd0);
    chk("fl_insn", ex_insn_o, NOP);
    chk("fl_rd_hold", {27'd0, ex_rd_o}, 32'd7);
    flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
    tick();
    chk("fl_dropped", 32'(ex_valid_o), 32'd0);

    // Flush wins over a load-use stall
    offer(5'd1, 5'd0, 5'd6, 1, 0, 1, 1, 32'h0000a303, 32'd0, 32'd0);
    tick();
    offer(5'd6, 5'd0, 5'd7, 1, 1, 1, 0, 32'h000303b3, 32'h66, 32'd0);
    flush_i = 1'b1;
    #1;
    chk("fls_ready", 32'(id_ready_o), 32'd1);
    tick();
    chk("fls_valid", 32'(ex_valid_o), 32'd0);
    chk("fls_insn", ex_insn_o, NOP);
    flush_i = 1'b0;

    // Reset while stalled discards the held instruction
    offer(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 32'h002081b3, 32'd5, 32'd7);
    tick();
    ex_ready_i = 1'b0;
    tick();
    chk("rs_held", 32'(ex_valid_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rs_valid", 32'(ex_valid_o), 32'd0);
    chk("rs_insn", ex_insn_o, NOP);
    chk("rs_rd", {27'd0, ex_rd_o}, 32'd0);
    chk("rs_ready", 32'(id_ready_o), 32'd0);
    rst = 1'b1;
    id_valid_i = 1'b0; ex_ready_i = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
